// File: rtl/count_set_sequencer.sv
// Purpose: buffers counter load requests and replays them as spaced, one-cycle set pulses.
// Latency: a command pushed into an empty, idle sequencer drives set one cycle after the next edge.
// Backpressure: cmd_ready drops while the FIFO holds DEPTH entries; issue can also stall on zero.
module count_set_sequencer #(
  parameter int DEPTH     = 4,
  parameter int GAP       = 2,
  parameter bit WAIT_ZERO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [3:0]               cmd_num,
  output logic                     cmd_ready,
  input  logic                     zero,
  output logic                     set,
  output logic [3:0]               set_num,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [3:0]    GAP_LD = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_WAITZ
  } state_t;

  // State entered right after an issue: spacing first, then the zero wait, else straight back.
  localparam state_t EXIT_ST = (GAP > 0) ? S_GAP : (WAIT_ZERO ? S_WAITZ : S_IDLE);

  state_t          state;
  logic [3:0]      gap_cnt;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic            nonempty;

  // Ready is a pure function of the registered occupancy, so a full FIFO never
  // accepts even when a pop happens in the same cycle.
  assign cmd_ready = (level != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign nonempty  = (level != '0);
  assign busy      = (state != S_IDLE) || nonempty;

  // Issue decision: pops the FIFO head in the cycle the FSM allows a new pulse.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = nonempty;
      S_GAP:   pop = (gap_cnt == 4'd0) && !WAIT_ZERO && nonempty;
      S_WAITZ: pop = zero && nonempty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since level/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_num;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue FSM with registered strobe, load value and pulse counter.
  // gap_cnt is loaded with GAP on issue; the pulse cycle itself counts as the
  // first GAP-state cycle, so the next issue lands exactly GAP+1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gap_cnt    <= 4'd0;
      set        <= 1'b0;
      set_num    <= 4'd0;
      issued_cnt <= 8'd0;
    end else begin
      set <= pop;
      if (pop) begin
        set_num    <= mem[rd_ptr];
        issued_cnt <= issued_cnt + 8'd1;
        state      <= EXIT_ST;
        gap_cnt    <= GAP_LD;
      end else begin
        case (state)
          S_GAP: begin
            if (gap_cnt == 4'd0) begin
              state <= WAIT_ZERO ? S_WAITZ : S_IDLE;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          S_WAITZ: begin
            // zero with nothing queued releases the FSM so the next command
            // issues without another zero handshake.
            if (zero) begin
              state <= S_IDLE;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_set_sequencer.sv
// Bench for count_set_sequencer: three instances (GAP=2/WZ=0, GAP=0/WZ=1, GAP=1/WZ=1)
// driven by directed sequences then random traffic; a timing-rule reference model
// predicts each set pulse and a negedge monitor scores the DUT outputs against it.
module tb_count_set_sequencer;

  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic       cmd_valid [3];
  logic [3:0] cmd_num   [3];
  logic       cmd_ready [3];
  logic       zero      [3];
  logic       set_o     [3];
  logic [3:0] set_num   [3];
  logic       busy      [3];
  logic [2:0] level     [3];
  logic [7:0] issued_cnt[3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int inst, input int act, input int want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", nm, inst, $time, act, want);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int G  = (gi == 0) ? 2 : ((gi == 1) ? 0 : 1);
    localparam bit WZ = (gi == 0) ? 1'b0 : 1'b1;

    count_set_sequencer #(.DEPTH(4), .GAP(G), .WAIT_ZERO(WZ)) dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .cmd_valid  (cmd_valid[gi]),
      .cmd_num    (cmd_num[gi]),
      .cmd_ready  (cmd_ready[gi]),
      .zero       (zero[gi]),
      .set        (set_o[gi]),
      .set_num    (set_num[gi]),
      .busy       (busy[gi]),
      .level      (level[gi]),
      .issued_cnt (issued_cnt[gi])
    );

    // Reference model state: queued commands, scheduled pulses, last issue edge.
    logic [3:0] mq[$];
    exp_t       sq[$];
    int         en       = 0;
    int         last_iss = -100;
    bit         released = 1'b1;
    logic [7:0] icnt     = 8'd0;
    logic [3:0] lastv    = 4'd0;

    // Model: pulses are due when the FIFO holds something and the timing rules
    // (GAP+1 edges since last issue, or a sampled zero) permit it.
    initial forever begin
      @(posedge clk);
      en++;
      if (rst[gi]) begin
        mq.delete();
        released = 1'b1;
        last_iss = -100;
        icnt     = 8'd0;
        lastv    = 4'd0;
      end else begin
        int   sz;
        int   zs;
        bit   open;
        bit   acc;
        exp_t x;
        sz = mq.size();
        if (WZ) begin
          zs   = last_iss + G + 1 + ((G > 0) ? 1 : 0);
          open = released || ((en >= zs) && zero[gi]);
          if (!released && sz == 0 && en >= zs && zero[gi]) released = 1'b1;
        end else begin
          open = (en >= last_iss + G + 1);
        end
        acc = cmd_valid[gi] && (sz != 4);
        if (open && sz != 0) begin
          x.e      = en;
          x.v      = mq.pop_front();
          sq.push_back(x);
          last_iss = en;
          released = 1'b0;
          icnt     = icnt + 8'd1;
          lastv    = x.v;
        end
        if (acc) mq.push_back(cmd_num[gi]);
      end
    end

    // Monitor: compares every visible output once per cycle, away from the edge.
    initial forever begin
      @(negedge clk);
      if (en > 0) begin
        bit   idle;
        exp_t x;
        idle = WZ ? released : ((G == 0) || (en >= last_iss + G + 1));
        check("level",      gi, int'(level[gi]),      mq.size());
        check("cmd_ready",  gi, int'(cmd_ready[gi]),  int'(mq.size() != 4));
        check("busy",       gi, int'(busy[gi]),       int'((mq.size() != 0) || !idle));
        check("issued_cnt", gi, int'(issued_cnt[gi]), int'(icnt));
        check("set_num",    gi, int'(set_num[gi]),    int'(lastv));
        if (set_o[gi]) begin
          check("set_was_due", gi, int'(sq.size() != 0), 1);
          if (sq.size() != 0) begin
            x = sq.pop_front();
            check("set_edge", gi, en, x.e);
            check("set_val",  gi, int'(set_num[gi]), int'(x.v));
          end
        end else if (sq.size() != 0 && sq[0].e <= en) begin
          x = sq.pop_front();
          check("set_missing", gi, int'(set_o[gi]), 1);
        end
      end
    end
  end

  task automatic idle_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds cmd_valid until the DUT accepts, with a bounded wait.
  task automatic push(input int i, input logic [3:0] v);
    bit acc;
    acc = 1'b0;
    cmd_valid[i] = 1'b1;
    cmd_num[i]   = v;
    for (int t = 0; t < 200; t++) begin
      acc = cmd_ready[i];
      @(negedge clk);
      if (acc) break;
    end
    check("push_accepted", i, int'(acc), 1);
    cmd_valid[i] = 1'b0;
  endtask

  task automatic pulse_rst(input int i);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic random_phase(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      cmd_valid[i] = 1'($urandom_range(0, 1));
      cmd_num[i]   = 4'($urandom_range(0, 15));
      zero[i]      = ($urandom_range(0, 3) == 0);
      rst[i]       = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    cmd_valid[i] = 1'b0;
    rst[i]       = 1'b0;
    zero[i]      = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      cmd_valid[i] = 1'b0;
      cmd_num[i]   = 4'd0;
      zero[i]      = 1'b0;
    end
    idle_cyc(2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    fork
      begin
        // GAP=2: single command, held-valid burst, then reset during a gap.
        push(0, 4'd9);
        idle_cyc(8);
        for (int v = 1; v <= 8; v++) push(0, 4'(v));
        idle_cyc(30);
        push(0, 4'd1);
        push(0, 4'd2);
        push(0, 4'd3);
        idle_cyc(1);
        pulse_rst(0);
        push(0, 4'd5);
        idle_cyc(10);
        random_phase(0, 300);
      end
      begin
        // GAP=0, WAIT_ZERO: stall in the zero wait, queue four, then release.
        zero[1] = 1'b0;
        push(1, 4'd7);
        push(1, 4'd4);
        push(1, 4'd3);
        push(1, 4'd2);
        push(1, 4'd1);
        idle_cyc(3);
        zero[1] = 1'b1;
        idle_cyc(8);
        random_phase(1, 300);
      end
      begin
        // GAP=1, WAIT_ZERO: second command waits for zero.
        zero[2] = 1'b0;
        push(2, 4'd10);
        push(2, 4'd11);
        idle_cyc(10);
        zero[2] = 1'b1;
        idle_cyc(5);
        zero[2] = 1'b0;
        idle_cyc(3);
        zero[2] = 1'b1;
        idle_cyc(2);
        random_phase(2, 300);
      end
    join

    idle_cyc(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
